sdfm_bus_master: RTL and testbench



---
 rtl/sdfm_bus_pkg.sv | 60 ++++++
 rtl/sdfm_bus_master_timer.sv | 27 ++
 rtl/sdfm_bus_master.sv | 148 ++++++++++++++
 tb/tb_sdfm_bus_master.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdfm_bus_pkg.sv
// Shared definitions for the SDFM external register bus: master FSM encoding,
// register map addresses and DFPARM field layout.
package sdfm_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } bus_state_e;

    localparam logic [7:0] DEV_SDFM    = 8'h07;
    localparam logic [7:0] REG_CTL     = 8'h08;
    localparam logic [7:0] REG_DFPARM0 = 8'h0C;
    localparam logic [7:0] REG_DFPARM1 = 8'h10;

    localparam int DFPARM_DOSR_LSB = 0;
    localparam int DFPARM_DOSR_MSB = 7;
    localparam int DFPARM_MOD_LSB  = 8;
    localparam int DFPARM_MOD_MSB  = 9;
    localparam int DFPARM_DIV_LSB  = 12;
    localparam int DFPARM_DIV_MSB  = 15;
    localparam int DFPARM_FEN_BIT  = 16;
    localparam int DFPARM_AEN_BIT  = 17;
    localparam int DFPARM_STF_LSB  = 20;
    localparam int DFPARM_STF_MSB  = 21;

    // Phase length in cycles -> down-counter load value; 0 behaves as 1, >255 saturates
    function automatic logic [7:0] phase_load(input int cycles);
        logic [7:0] load_v;
        if (cycles <= 1) begin
            load_v = 8'd0;
        end else if (cycles >= 255) begin
            load_v = 8'd254;
        end else begin
            load_v = 8'(cycles - 1);
        end
        return load_v;
    endfunction

    function automatic logic [31:0] dfparm_pack(
        input logic [7:0] dosr,
        input logic [1:0] modsel,
        input logic [3:0] div,
        input logic       fen,
        input logic       aen,
        input logic [1:0] stf
    );
        logic [31:0] word_v;
        word_v = 32'h0000_0000;
        word_v[DFPARM_DOSR_MSB:DFPARM_DOSR_LSB] = dosr;
        word_v[DFPARM_MOD_MSB:DFPARM_MOD_LSB]   = modsel;
        word_v[DFPARM_DIV_MSB:DFPARM_DIV_LSB]   = div;
        word_v[DFPARM_FEN_BIT]                  = fen;
        word_v[DFPARM_AEN_BIT]                  = aen;
        word_v[DFPARM_STF_MSB:DFPARM_STF_LSB]   = stf;
        return word_v;
    endfunction

endpackage

// File: rtl/sdfm_bus_master_timer.sv
// Loadable 8-bit phase down-counter; zero is asserted while the count is 0.
module bus_phase_timer (
    input  logic       EXTCLK,
    input  logic       EXTRSTn,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] count_r;

    // Reload on phase entry, otherwise count down and rest at zero
    always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
        if (!EXTRSTn) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != 8'd0) begin
            count_r <= count_r - 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 8'd0);

endmodule

// File: rtl/sdfm_bus_master.sv
// SDFM register-bus initiator: valid/ready commands in, timed WR/RD strobe
// cycles on ADDR/DATA out, one-cycle response pulse with captured read data.
module sdfm_bus_master
    import sdfm_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1,
    parameter int HOLD_CYC   = 1
) (
    input  logic        EXTCLK,
    input  logic        EXTRSTn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        WR,
    output logic        RD,
    output logic [15:0] ADDR,
    inout  wire  [31:0] DATA
);

    localparam logic [7:0] SETUP_LD  = phase_load(SETUP_CYC);
    localparam logic [7:0] STROBE_LD = phase_load(STROBE_CYC);
    localparam logic [7:0] HOLD_LD   = phase_load(HOLD_CYC);

    bus_state_e  state_r;
    bus_state_e  state_nx_s;
    logic        accept_s;
    logic        timer_load_s;
    logic [7:0]  timer_val_s;
    logic        phase_zero_s;

    logic        write_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        wr_r;
    logic        rd_r;
    logic [15:0] addr_r;
    logic [31:0] data_out_r;
    logic        data_oe_r;

    bus_phase_timer u_timer (
        .EXTCLK   (EXTCLK),
        .EXTRSTn  (EXTRSTn),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .zero     (phase_zero_s)
    );

    // Next-state and phase-timer reload decode
    always_comb begin
        state_nx_s   = state_r;
        accept_s     = 1'b0;
        timer_load_s = 1'b0;
        timer_val_s  = 8'd0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s     = 1'b1;
                    state_nx_s   = ST_SETUP;
                    timer_load_s = 1'b1;
                    timer_val_s  = SETUP_LD;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (phase_zero_s) begin
                    state_nx_s   = ST_STROBE;
                    timer_load_s = 1'b1;
                    timer_val_s  = STROBE_LD;
                end else begin
                    state_nx_s   = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (phase_zero_s) begin
                    state_nx_s   = ST_HOLD;
                    timer_load_s = 1'b1;
                    timer_val_s  = HOLD_LD;
                end else begin
                    state_nx_s   = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (phase_zero_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered bus outputs, all derived from the next state
    always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
        if (!EXTRSTn) begin
            state_r     <= ST_IDLE;
            write_r     <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            wr_r        <= 1'b0;
            rd_r        <= 1'b0;
            addr_r      <= 16'h0000;
            data_out_r  <= 32'h0000_0000;
            data_oe_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            req_ready_r <= (state_nx_s == ST_IDLE);
            rsp_valid_r <= (state_r == ST_HOLD) && phase_zero_s;
            // write_r is stable before STROBE is ever entered, since SETUP lasts at least one cycle
            wr_r        <= (state_nx_s == ST_STROBE) && write_r;
            rd_r        <= (state_nx_s == ST_STROBE) && !write_r;
            if (accept_s) begin
                write_r    <= req_write;
                addr_r     <= req_addr;
                data_out_r <= req_wdata;
                data_oe_r  <= req_write;
            end else if (state_nx_s == ST_IDLE) begin
                data_oe_r  <= 1'b0;
            end else begin
                data_oe_r  <= data_oe_r;
            end
            if ((state_r == ST_STROBE) && phase_zero_s && !write_r) begin
                rsp_rdata_r <= DATA;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign WR        = wr_r;
    assign RD        = rd_r;
    assign ADDR      = addr_r;
    assign DATA      = data_oe_r ? data_out_r : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_sdfm_bus_master.sv
// Scoreboard bench: bus A uses default timing with a register-file responder,
// bus B uses SETUP=2, STROBE=3, HOLD=2 for writes.
module tb_sdfm_bus_master;
    import sdfm_bus_pkg::*;

    logic EXTCLK = 1'b0;
    logic EXTRSTn;
    always #5 EXTCLK = ~EXTCLK;

    logic        a_req_valid, a_req_write, a_req_ready, a_rsp_valid, a_WR, a_RD;
    logic [15:0] a_req_addr, a_ADDR;
    logic [31:0] a_req_wdata, a_rsp_rdata;
    wire  [31:0] a_DATA;
    logic        b_req_valid, b_req_write, b_req_ready, b_rsp_valid, b_WR, b_RD;
    logic [15:0] b_req_addr, b_ADDR;
    logic [31:0] b_req_wdata, b_rsp_rdata;
    wire  [31:0] b_DATA;

    sdfm_bus_master dut_a (
        .EXTCLK(EXTCLK), .EXTRSTn(EXTRSTn),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .WR(a_WR), .RD(a_RD), .ADDR(a_ADDR), .DATA(a_DATA)
    );

    sdfm_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_b (
        .EXTCLK(EXTCLK), .EXTRSTn(EXTRSTn),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .WR(b_WR), .RD(b_RD), .ADDR(b_ADDR), .DATA(b_DATA)
    );

    // Responder register file on bus A
    logic [31:0] resp_mem [256] = '{12: 32'h0031_A20F, default: 32'h0000_0000};
    assign a_DATA = a_RD ? resp_mem[a_ADDR[7:0]] : 32'hzzzz_zzzz;
    always @(posedge EXTCLK) begin
        if (a_WR && (a_ADDR[15:8] == DEV_SDFM)) resp_mem[a_ADDR[7:0]] <= a_DATA;
    end

    typedef struct {
        int          n;
        logic        w;
        logic [15:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        qa[$];
    txn_t        qb[$];
    logic [31:0] ref_mem [logic [15:0]];
    logic [31:0] last_rd = 32'h0000_0000;
    int          cyc = 0;
    int          acc_a = 0;
    int          acc_b = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge EXTCLK) cyc <= cyc + 1;

    // Where cycle c falls relative to acceptance at the edge ending cycle n
    function automatic int phase_of(input int c, input int n, input int s, input int t, input int h);
        int d;
        d = c - n;
        if (d >= 1 && d <= s) return 1;
        if (d > s && d <= s + t) return 2;
        if (d > s + t && d <= s + t + h) return 3;
        if (d == s + t + h + 1) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        if (a == {DEV_SDFM, REG_DFPARM0}) return 32'h0031_A20F;
        return 32'h0000_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare both buses against the timeline model every cycle
    always @(negedge EXTCLK) begin
        int   ph;
        logic w;
        txn_t t;
        if (!EXTRSTn) begin
            qa.delete();
            qb.delete();
            last_rd = 32'h0000_0000;
            chk1("rst_a_wr", a_WR, 1'b0);
            chk1("rst_a_rd", a_RD, 1'b0);
            chk1("rst_a_data_z", a_DATA === 32'hzzzz_zzzz, 1'b1);
            chk1("rst_a_ready", a_req_ready, 1'b1);
            chk1("rst_a_rsp_valid", a_rsp_valid, 1'b0);
            chk("rst_a_rdata", a_rsp_rdata, 32'h0000_0000);
            chk("rst_a_addr", 32'(a_ADDR), 32'h0000_0000);
            chk1("rst_b_wr", b_WR, 1'b0);
            chk1("rst_b_ready", b_req_ready, 1'b1);
        end else begin
            ph = (qa.size() > 0) ? phase_of(cyc, qa[0].n, 1, 1, 1) : 0;
            w  = (qa.size() > 0) ? qa[0].w : 1'b0;
            chk1("a_ready", a_req_ready, ph == 0 || ph == 4);
            chk1("a_wr", a_WR, ph == 2 && w);
            chk1("a_rd", a_RD, ph == 2 && !w);
            chk1("a_rsp_valid", a_rsp_valid, ph == 4);
            if (ph >= 1 && ph <= 3) begin
                chk("a_addr", 32'(a_ADDR), 32'(qa[0].addr));
                if (w) chk("a_data_wr", a_DATA, qa[0].wdata);
                else if (ph == 2) chk("a_data_rd", a_DATA, resp_mem[qa[0].addr[7:0]]);
                else chk1("a_data_z", a_DATA === 32'hzzzz_zzzz, 1'b1);
            end else begin
                chk1("a_data_z", a_DATA === 32'hzzzz_zzzz, 1'b1);
            end
            if (ph == 4) begin
                t = qa.pop_front();
                if (t.w) ref_mem[t.addr] = t.wdata;
                else last_rd = ref_read(t.addr);
            end
            if (!(ph == 3 && !w)) chk("a_rdata", a_rsp_rdata, last_rd);
            if (a_req_valid && (ph == 0 || ph == 4)) begin
                qa.push_back('{cyc, a_req_write, a_req_addr, a_req_wdata});
                acc_a++;
            end

            ph = (qb.size() > 0) ? phase_of(cyc, qb[0].n, 2, 3, 2) : 0;
            chk1("b_ready", b_req_ready, ph == 0 || ph == 4);
            chk1("b_wr", b_WR, ph == 2);
            chk1("b_rd", b_RD, 1'b0);
            chk1("b_rsp_valid", b_rsp_valid, ph == 4);
            if (ph >= 1 && ph <= 3) begin
                chk("b_addr", 32'(b_ADDR), 32'(qb[0].addr));
                chk("b_data_wr", b_DATA, qb[0].wdata);
            end else begin
                chk1("b_data_z", b_DATA === 32'hzzzz_zzzz, 1'b1);
            end
            if (ph == 4) t = qb.pop_front();
            if (b_req_valid && (ph == 0 || ph == 4)) begin
                qb.push_back('{cyc, 1'b1, b_req_addr, b_req_wdata});
                acc_b++;
            end
        end
    end

    task automatic issue_a(input logic w, input logic [15:0] addr, input logic [31:0] d);
        int c0;
        c0 = acc_a;
        a_req_valid = 1'b1;
        a_req_write = w;
        a_req_addr  = addr;
        a_req_wdata = d;
        for (int k = 0; k < 64 && acc_a == c0; k++) @(posedge EXTCLK);
        if (acc_a == c0) begin
            $display("FAIL handshake_a timeout at cyc=%0d", cyc);
            $fatal(1);
        end
        #1 a_req_valid = 1'b0;
    endtask

    task automatic issue_b(input logic [15:0] addr, input logic [31:0] d);
        int c0;
        c0 = acc_b;
        b_req_valid = 1'b1;
        b_req_addr  = addr;
        b_req_wdata = d;
        for (int k = 0; k < 64 && acc_b == c0; k++) @(posedge EXTCLK);
        if (acc_b == c0) begin
            $display("FAIL handshake_b timeout at cyc=%0d", cyc);
            $fatal(1);
        end
        #1 b_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge EXTCLK);
        #1;
    endtask

    initial begin
        logic [7:0]  regsel [4];
        logic [31:0] wd;
        regsel[0] = REG_CTL;
        regsel[1] = REG_DFPARM0;
        regsel[2] = REG_DFPARM1;
        regsel[3] = 8'h14;
        EXTRSTn = 1'b0;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 16'h0000; a_req_wdata = 32'h0;
        b_req_valid = 1'b0; b_req_write = 1'b1; b_req_addr = 16'h0000; b_req_wdata = 32'h0;
        idle(3);
        EXTRSTn = 1'b1;
        idle(2);

        issue_a(1'b1, {DEV_SDFM, REG_CTL}, 32'h0000_0003);
        idle(5);
        issue_a(1'b0, {DEV_SDFM, REG_DFPARM0}, 32'h0);
        idle(5);
        // Write then read with no gap: read accepted in the response cycle
        issue_a(1'b1, {DEV_SDFM, REG_DFPARM1}, 32'h0012_3A55);
        issue_a(1'b0, {DEV_SDFM, REG_DFPARM1}, 32'h0);
        idle(6);

        issue_b({DEV_SDFM, REG_CTL}, 32'hA5A5_0001);
        issue_b({DEV_SDFM, REG_DFPARM0}, 32'h0031_A20F);
        idle(12);

        // Held request for 10 cycles
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = {DEV_SDFM, REG_CTL};
        idle(10);
        a_req_valid = 1'b0;
        idle(6);

        // Reset during the STROBE cycle of a write
        issue_a(1'b1, {DEV_SDFM, REG_CTL}, 32'hDEAD_0007);
        @(posedge EXTCLK);
        #2 EXTRSTn = 1'b0;
        idle(2);
        EXTRSTn = 1'b1;
        idle(8);
        issue_a(1'b0, {DEV_SDFM, REG_CTL}, 32'h0);
        idle(5);

        for (int i = 0; i < 60; i++) begin
            wd = $urandom;
            issue_a(1'($urandom_range(0, 1)), {DEV_SDFM, regsel[$urandom_range(0, 3)]}, wd);
            idle($urandom_range(0, 3));
        end
        idle(20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
